// File: rtl/wave_pkg.sv
// Shared types and default sizing for the waveform-generator datapath.
package wave_pkg;

  localparam int WAVE_WIDTH = 24;
  localparam int WAVE_DEPTH = 1024;
  localparam int WAVE_ACC_W = 32;

  typedef enum logic [1:0] {
    SINE     = 2'd0,
    SQUARE   = 2'd1,
    TRIANGLE = 2'd2,
    SAWTOOTH = 2'd3
  } wave_sel_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } seq_state_e;

endpackage

// File: rtl/phase_accumulator.sv
// Phase accumulator register; carry flags the wrap that closes one waveform period.
module phase_accumulator #(
  parameter int ACC_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [ACC_W-1:0] step,
  output logic [ACC_W-1:0] acc,
  output logic             carry
);

  logic [ACC_W:0] sum;

  assign sum   = {1'b0, acc} + {1'b0, step};
  assign carry = sum[ACC_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= sum[ACC_W-1:0];
    end
  end

endmodule

// File: rtl/wave_sequencer.sv
// Burst controller: steps the shared phase index, selects one generator output
// and streams it on a valid/ready interface for N periods or continuously.
module wave_sequencer
  import wave_pkg::*;
#(
  parameter  int WIDTH = WAVE_WIDTH,
  parameter  int DEPTH = WAVE_DEPTH,
  parameter  int ACC_W = WAVE_ACC_W,
  localparam int PW    = $clog2(DEPTH)
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_cfg_we,
  input  logic [ACC_W-1:0]        i_cfg_ftw,
  input  logic [1:0]              i_cfg_sel,
  input  logic [15:0]             i_cfg_cycles,
  input  logic                    i_start,
  input  logic                    i_stop,
  output logic [PW-1:0]           o_phase_count,
  input  logic signed [WIDTH-1:0] i_sine_wave,
  input  logic signed [WIDTH-1:0] i_square_wave,
  input  logic signed [WIDTH-1:0] i_triangle_wave,
  input  logic signed [WIDTH-1:0] i_sawtooth_wave,
  output logic signed [WIDTH-1:0] o_sample,
  output logic                    o_valid,
  input  logic                    i_ready,
  output logic                    o_busy,
  output logic                    o_done
);

  seq_state_e              state;
  logic [ACC_W-1:0]        ftw;
  wave_sel_e               sel;
  logic [15:0]             cycles;
  logic [15:0]             count;
  logic [ACC_W-1:0]        acc;
  logic                    carry;
  logic                    load;
  logic                    acc_clr;
  logic                    acc_en;
  logic                    last;
  logic signed [WIDTH-1:0] mux_sample;
  logic                    unused_acc_bits;

  // A new sample may be loaded whenever the output slot is empty or being drained.
  assign load    = !o_valid || i_ready;
  assign acc_clr = (state == IDLE) && i_start && !i_stop;
  assign acc_en  = (state == RUN) && !i_stop && load;
  assign last    = carry && (cycles != 16'd0) && ((count + 16'd1) == cycles);

  assign o_phase_count   = acc[ACC_W-1 -: PW];
  assign unused_acc_bits = ^acc[ACC_W-PW-1:0];
  assign o_busy          = (state != IDLE);

  phase_accumulator #(
    .ACC_W (ACC_W)
  ) u_phase_acc (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .clr   (acc_clr),
    .en    (acc_en),
    .step  (ftw),
    .acc   (acc),
    .carry (carry)
  );

  always_comb begin
    mux_sample = i_sine_wave;
    case (sel)
      SINE:     mux_sample = i_sine_wave;
      SQUARE:   mux_sample = i_square_wave;
      TRIANGLE: mux_sample = i_triangle_wave;
      SAWTOOTH: mux_sample = i_sawtooth_wave;
      default:  mux_sample = i_sine_wave;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= IDLE;
      ftw      <= '0;
      sel      <= SINE;
      cycles   <= '0;
      count    <= '0;
      o_sample <= '0;
      o_valid  <= 1'b0;
      o_done   <= 1'b0;
    end else begin
      o_done <= 1'b0;
      case (state)
        IDLE: begin
          if (i_cfg_we) begin
            ftw    <= i_cfg_ftw;
            sel    <= wave_sel_e'(i_cfg_sel);
            cycles <= i_cfg_cycles;
          end
          if (i_start && !i_stop) begin
            state <= RUN;
            count <= '0;
          end
        end
        RUN: begin
          // A stop edge loads nothing, but a sample accepted on it is gone.
          if (i_stop) begin
            if (o_valid && i_ready) begin
              o_valid <= 1'b0;
            end
            state <= DRAIN;
          end else if (load) begin
            o_sample <= mux_sample;
            o_valid  <= 1'b1;
            if (carry) begin
              count <= count + 16'd1;
            end
            if (last) begin
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (load) begin
            o_valid <= 1'b0;
            o_done  <= 1'b1;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wave_sequencer.sv
// Directed bench for wave_sequencer with simple arithmetic stand-ins for the generators.
module tb_wave_sequencer;
  import wave_pkg::*;

  localparam int WIDTH = 24;
  localparam int DEPTH = 1024;
  localparam int ACC_W = 32;
  localparam int PW    = 10;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic                    cfg_we;
  logic [ACC_W-1:0]        cfg_ftw;
  logic [1:0]              cfg_sel;
  logic [15:0]             cfg_cycles;
  logic                    start;
  logic                    stop;
  logic                    ready;
  logic [PW-1:0]           phase;
  logic [WIDTH-1:0]        sine_w, square_w, tri_w, saw_w;
  logic signed [WIDTH-1:0] sample;
  logic                    valid, busy, done;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] got_q[$];
  bit          fin;

  always #5 clk = ~clk;

  // Generator stand-ins: distinct linear functions of the phase index.
  assign sine_w   = {14'd0, phase} + 24'd1000;
  assign square_w = {14'd0, phase} * 24'd3 + 24'd77;
  assign tri_w    = {14'd0, phase} * 24'd7 + 24'd5;
  assign saw_w    = {14'd0, phase} * 24'd2 + 24'd9;

  wave_sequencer #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .ACC_W (ACC_W)
  ) dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_cfg_we        (cfg_we),
    .i_cfg_ftw       (cfg_ftw),
    .i_cfg_sel       (cfg_sel),
    .i_cfg_cycles    (cfg_cycles),
    .i_start         (start),
    .i_stop          (stop),
    .o_phase_count   (phase),
    .i_sine_wave     (sine_w),
    .i_square_wave   (square_w),
    .i_triangle_wave (tri_w),
    .i_sawtooth_wave (saw_w),
    .o_sample        (sample),
    .o_valid         (valid),
    .i_ready         (ready),
    .o_busy          (busy),
    .o_done          (done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic configure(input logic [31:0] ftw, input logic [1:0] sel, input logic [15:0] cyc);
    @(negedge clk);
    cfg_we = 1'b1; cfg_ftw = ftw; cfg_sel = sel; cfg_cycles = cyc;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  // Starts a burst, records every transfer, optionally stalls, stops or
  // writes config mid-burst, and checks the done pulse placement.
  task automatic run_burst(input int stop_after, input bit stall, input bit cfg_mid,
                           input int budget, input int exp_gap);
    bit          prev_stall = 1'b0;
    logic [31:0] prev_s = '0;
    int          last_x = -1;
    bit          stopped = 1'b0;
    got_q.delete();
    fin = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_busy", {31'd0, busy}, 32'd1);
    check("start_valid", {31'd0, valid}, 32'd0);
    check("start_phase", {22'd0, phase}, 32'd0);
    for (int c = 0; c < budget && !fin; c++) begin
      ready = stall ? ((c % 4 == 0) || (c % 4 == 3)) : 1'b1;
      if (stop_after > 0 && !stopped && got_q.size() >= stop_after) begin
        stop = 1'b1;
        stopped = 1'b1;
      end
      if (cfg_mid && c == 2) begin
        cfg_we = 1'b1;
        cfg_sel = 2'd3;
      end
      if (c == 1) check("lat_valid", {31'd0, valid}, 32'd1);
      if (prev_stall) begin
        check("hold_valid", {31'd0, valid}, 32'd1);
        check("hold_sample", sample, prev_s);
      end
      prev_stall = valid && !ready;
      prev_s = sample;
      if (valid && ready) begin
        got_q.push_back(sample);
        last_x = c;
      end
      @(negedge clk);
      stop = 1'b0;
      cfg_we = 1'b0;
      if (done) begin
        fin = 1'b1;
        check("done_gap", c - last_x, exp_gap);
      end
    end
    if (!fin) check("timeout", 32'd0, 32'd1);
    ready = 1'b1;
    @(negedge clk);
    check("done_pulse", {31'd0, done}, 32'd0);
    check("idle_busy", {31'd0, busy}, 32'd0);
    check("idle_valid", {31'd0, valid}, 32'd0);
  endtask

  initial begin
    logic [31:0] tri_tab[4];
    logic [31:0] saw_tab[4];
    tri_tab = '{32'd5, 32'd1797, 32'd3589, 32'd5381};
    saw_tab = '{32'd9, 32'd521, 32'd1033, 32'd1545};

    rst_n = 1'b0; cfg_we = 1'b0; cfg_ftw = '0; cfg_sel = '0; cfg_cycles = '0;
    start = 1'b0; stop = 1'b0; ready = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_valid", {31'd0, valid}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_sample", sample, 32'd0);
    check("rst_phase", {22'd0, phase}, 32'd0);

    // Shadows are zero after reset: sine at phase 0 repeats until stopped.
    run_burst(3, 1'b0, 1'b0, 50, 1);
    check("ftw0_count", got_q.size(), 32'd4);
    for (int i = 0; i < 4; i++) check("ftw0_sample", got_q[i], 32'd1000);

    configure(32'h4000_0000, 2'd2, 16'd2);
    run_burst(0, 1'b0, 1'b0, 100, 0);
    check("tri_count", got_q.size(), 32'd8);
    for (int i = 0; i < 8; i++) check("tri_sample", got_q[i], tri_tab[i % 4]);

    run_burst(0, 1'b1, 1'b0, 200, 0);
    check("stall_count", got_q.size(), 32'd8);
    for (int i = 0; i < 8; i++) check("stall_sample", got_q[i], tri_tab[i % 4]);

    configure(32'h8000_0000, 2'd0, 16'd0);
    run_burst(5, 1'b0, 1'b0, 100, 1);
    check("cont_count", got_q.size(), 32'd6);
    for (int i = 0; i < 6; i++) check("cont_sample", got_q[i], (i % 2 == 0) ? 32'd1000 : 32'd1512);

    @(negedge clk);
    start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    check("ss_busy", {31'd0, busy}, 32'd0);
    check("ss_valid", {31'd0, valid}, 32'd0);
    @(negedge clk);
    check("ss_valid2", {31'd0, valid}, 32'd0);
    check("ss_busy2", {31'd0, busy}, 32'd0);

    configure(32'h4000_0000, 2'd2, 16'd1);
    run_burst(0, 1'b0, 1'b1, 100, 0);
    check("cfgrun_count", got_q.size(), 32'd4);
    for (int i = 0; i < 4; i++) check("cfgrun_sample", got_q[i], tri_tab[i]);
    run_burst(0, 1'b0, 1'b0, 100, 0);
    check("cfgnext_count", got_q.size(), 32'd4);
    for (int i = 0; i < 4; i++) check("cfgnext_sample", got_q[i], tri_tab[i]);

    configure(32'h4000_0000, 2'd3, 16'd1);
    run_burst(0, 1'b0, 1'b0, 100, 0);
    check("saw_count", got_q.size(), 32'd4);
    for (int i = 0; i < 4; i++) check("saw_sample", got_q[i], saw_tab[i]);

    configure(32'h4000_0000, 2'd2, 16'd0);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_rst_valid", {31'd0, valid}, 32'd1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_sample", sample, 32'd0);
    check("arst_valid", {31'd0, valid}, 32'd0);
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_done", {31'd0, done}, 32'd0);
    check("arst_phase", {22'd0, phase}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_phase", {22'd0, phase}, 32'd0);
    check("post_rst_busy", {31'd0, busy}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wave_sequencer.md
# wave_sequencer

Controller that sequences the waveform-generator datapath. It owns a phase accumulator and drives the shared phase index into the sine, square, triangle and sawtooth generators. It selects one generator output, registers it, and streams it out on a valid/ready interface. Bursts run for a programmable number of full waveform periods, or continuously, under start/stop control.

## Interface
- WIDTH, 24, sample width; must match the wave generators.
- DEPTH, 1024, phase points per period (power of 2); PW = $clog2(DEPTH).
- ACC_W, 32, phase accumulator width; ACC_W > PW.
- i_clk  in  1  clock; all logic on rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_cfg_we  in  1  config write strobe; accepted only in IDLE, ignored otherwise.
- i_cfg_ftw  in  ACC_W  frequency tuning word (phase step per sample).
- i_cfg_sel  in  2  wave select: 0 sine, 1 square, 2 triangle, 3 sawtooth.
- i_cfg_cycles  in  16  periods per burst; 0 = continuous.
- i_start  in  1  start-burst pulse.
- i_stop  in  1  stop request.
- o_phase_count  out  PW  phase index to the generators, = acc[ACC_W-1 -: PW].
- i_sine_wave, i_square_wave, i_triangle_wave, i_sawtooth_wave  in  WIDTH each  combinational generator outputs for o_phase_count.
- o_sample  out  WIDTH  registered selected sample.
- o_valid  out  1  sample valid.
- i_ready  in  1  downstream accepts.
- o_busy  out  1  state != IDLE.
- o_done  out  1  one-cycle pulse on return to IDLE.

## Operation
- Shadow registers hold ftw, sel and cycles. They load on i_cfg_we in IDLE and reset to 0.
- States:
  - IDLE → RUN on i_start && !i_stop. i_stop wins when both are asserted. On entry to RUN: acc ← 0, period count ← 0.
  - RUN: on each load (load = !o_valid || i_ready):
    - o_sample ← mux(sel), o_valid ← 1, {carry, acc} ← acc + ftw.
    - Carry = 1 completes one period: count ← count + 1.
    - If cycles != 0 and count + 1 == cycles on a carry load, go to DRAIN after that load. The sample loaded on that edge is the last one.
    - RUN with no load (stall) holds acc, count, o_sample and o_valid.
  - RUN → DRAIN on i_stop, sampled at any edge. No load occurs on that edge.
  - DRAIN: no new loads. Once o_valid == 0 or i_ready == 1, clear o_valid, go to IDLE, pulse o_done.
- Handshake rules:
  - o_sample is stable while o_valid && !i_ready.
  - A transfer happens on an edge with o_valid && i_ready.
  - o_valid never drops without a transfer, except on reset.
- i_start in RUN or DRAIN is ignored.
- Config written during a burst is ignored. The burst always uses the shadow values latched before start.
- ftw = 0 in RUN repeats phase 0 forever. With cycles != 0 the burst then ends only via i_stop.
- Reset at any time: IDLE, acc 0, count 0, shadow registers 0. o_sample 0, o_valid 0, o_busy 0, o_done 0, o_phase_count 0.

## Timing
- i_start sampled at edge t: o_busy = 1 after t, acc = 0, o_phase_count = 0.
- Edge t+1: o_valid = 1 and o_sample = wave(phase 0). This is 2-cycle start latency.
- Throughput is 1 sample/cycle while i_ready = 1.
- Final transfer at edge u: o_done = 1 and o_busy = 0 after u, for one cycle.
- i_stop at edge s with o_valid = 0: IDLE after s+1.
- The generator path is combinational from the acc register. The only output-path register is o_sample.

## Structure
- Shared package wave_pkg holds:
  - wave_sel_e: SINE, SQUARE, TRIANGLE, SAWTOOTH.
  - seq_state_e: IDLE, RUN, DRAIN.
  - Default WIDTH/DEPTH constants.
- One sub-module, phase_accumulator: ACC_W register with clear, enable and step inputs. It outputs acc and the carry of acc + step.
- The FSM, shadow registers, period counter and output register live in wave_sequencer.

## Test plan
- Reset mid-burst (ftw = 2^30, RUN with o_valid = 1), assert i_rst_n = 0 → all outputs 0 immediately; acc 0 after release.
- Config sel = 2, ftw = 2^30, cycles = 2, start, i_ready = 1 → 8 samples with phases 0, 256, 512, 768 repeated twice; each o_sample equals i_triangle_wave for that phase; o_done 1 cycle after the 8th transfer.
- Same burst with i_ready toggling 1, 0, 0, 1 → o_sample is held during stalls; same 8 samples in the same order; no duplicates or drops.
- cycles = 0, ftw = 2^31, i_stop after 5 transfers → phases alternate 0/512; at most one outstanding sample drains; IDLE afterwards.
- i_start and i_stop asserted in the same IDLE cycle → remains IDLE; o_valid stays 0.
- i_cfg_we with sel = 3 during RUN → output still uses the original sel; the next burst also uses it, because the write was ignored.
